// File: rtl/paddle_input_controller_pkg.sv
// Shared constants and helpers for the paddle input path.
// Contents:
//   SCREEN_H, PADDLE_* defaults, LOC_W (paddle position width)
//   dir_e   : decoded movement direction (NONE / UP / DOWN, 2 bits)
//   step_loc: one clamped movement step, computed in 11 bits so it never wraps
package paddle_input_controller_pkg;

    localparam int unsigned SCREEN_H              = 480;
    localparam int unsigned PADDLE_HEIGHT_DEFAULT = 64;
    localparam int unsigned PADDLE_STEP_DEFAULT   = 4;
    localparam int unsigned PADDLE_INIT_DEFAULT   = 208;
    localparam int unsigned LOC_W                 = 10;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    // Moves loc one step in dir and clamps the result into [min_loc, max_loc].
    function automatic logic [LOC_W-1:0] step_loc(
        input logic [LOC_W-1:0] loc,
        input dir_e             dir,
        input int unsigned      step,
        input int unsigned      min_loc,
        input int unsigned      max_loc
    );
        logic [LOC_W:0]   wide;
        logic [LOC_W-1:0] result;
        wide   = {1'b0, loc};
        result = loc;
        case (dir)
            DIR_UP: begin
                if (wide < 11'(min_loc + step))
                    result = LOC_W'(min_loc);
                else
                    result = LOC_W'(wide - 11'(step));
            end
            DIR_DOWN: begin
                if (wide + 11'(step) > 11'(max_loc))
                    result = LOC_W'(max_loc);
                else
                    result = LOC_W'(wide + 11'(step));
            end
            default: result = loc;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/paddle_input_controller_if.sv
// Player-side bundle of the paddle input controller.
//   inputs to the controller : btn_up_raw, btn_down_raw, step_en, freeze, center
//   outputs of the controller: paddle_loc[9:0], up_db, down_db, moving, at_top, at_bottom
// Modports: master = stimulus / game side, slave = paddle_input_controller.
interface paddle_input_controller_if;
    import paddle_input_controller_pkg::*;

    logic             btn_up_raw;
    logic             btn_down_raw;
    logic             step_en;
    logic             freeze;
    logic             center;
    logic [LOC_W-1:0] paddle_loc;
    logic             up_db;
    logic             down_db;
    logic             moving;
    logic             at_top;
    logic             at_bottom;

    modport master (
        output btn_up_raw, btn_down_raw, step_en, freeze, center,
        input  paddle_loc, up_db, down_db, moving, at_top, at_bottom
    );

    modport slave (
        input  btn_up_raw, btn_down_raw, step_en, freeze, center,
        output paddle_loc, up_db, down_db, moving, at_top, at_bottom
    );

endinterface

// File: rtl/paddle_input_controller_button_debouncer.sv
// Single-button conditioner: 2-flop synchronizer followed by a
// consecutive-sample debounce counter.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   btn_raw      : asynchronous bouncy button
//   btn_db       : debounced level, flips after DEBOUNCE_CYCLES disagreeing samples
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic       db_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            // Any agreeing sample restarts the count, so only an unbroken
            // run of DEBOUNCE_CYCLES disagreeing samples flips the level.
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/paddle_input_controller.sv
// Turns one player's raw up/down buttons into a debounced, rate-limited,
// clamped paddle top-edge position (screen y grows downward).
// Ports:
//   clk      : game clock, all logic on posedge
//   reset_n  : synchronous active-low reset
//   bus      : slave side of paddle_input_controller_if
//              (buttons, step_en, freeze, center in; paddle_loc, up_db,
//               down_db, moving, at_top, at_bottom out)
module paddle_input_controller
    import paddle_input_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PADDLE_STEP     = PADDLE_STEP_DEFAULT,
    parameter int unsigned PADDLE_HEIGHT   = PADDLE_HEIGHT_DEFAULT,
    parameter int unsigned PADDLE_MIN      = 0,
    parameter int unsigned PADDLE_MAX      = SCREEN_H - PADDLE_HEIGHT,
    parameter int unsigned PADDLE_INIT     = PADDLE_INIT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    paddle_input_controller_if.slave   bus
);

    logic             up_db;
    logic             down_db;
    dir_e             dir;
    logic [LOC_W-1:0] loc_q;
    logic [LOC_W-1:0] loc_next;
    logic             moving_q;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (bus.btn_up_raw),
        .btn_db  (up_db)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (bus.btn_down_raw),
        .btn_db  (down_db)
    );

    // Both buttons held cancel out.
    always_comb begin
        dir = DIR_NONE;
        if (up_db && !down_db)
            dir = DIR_UP;
        else if (down_db && !up_db)
            dir = DIR_DOWN;
    end

    // center beats freeze, freeze beats a step.
    always_comb begin
        loc_next = loc_q;
        if (bus.center)
            loc_next = LOC_W'(PADDLE_INIT);
        else if (!bus.freeze && bus.step_en && dir != DIR_NONE)
            loc_next = step_loc(loc_q, dir, PADDLE_STEP, PADDLE_MIN, PADDLE_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loc_q    <= LOC_W'(PADDLE_INIT);
            moving_q <= 1'b0;
        end else begin
            loc_q    <= loc_next;
            moving_q <= (loc_next != loc_q);
        end
    end

    assign bus.paddle_loc = loc_q;
    assign bus.up_db      = up_db;
    assign bus.down_db    = down_db;
    assign bus.moving     = moving_q;
    assign bus.at_top     = (loc_q == LOC_W'(PADDLE_MIN));
    assign bus.at_bottom  = (loc_q == LOC_W'(PADDLE_MAX));

endmodule

// File: tb/tb_paddle_input_controller.sv
// Directed testbench for paddle_input_controller: main instance with default
// parameters plus two instances started near the top and bottom limits.
module tb_paddle_input_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    paddle_input_controller_if pif();
    paddle_input_controller_if pif_t();
    paddle_input_controller_if pif_b();

    paddle_input_controller dut (
        .clk(clk), .reset_n(reset_n), .bus(pif.slave)
    );

    paddle_input_controller #(.PADDLE_INIT(6)) dut_top (
        .clk(clk), .reset_n(reset_n), .bus(pif_t.slave)
    );

    paddle_input_controller #(.PADDLE_INIT(414)) dut_bot (
        .clk(clk), .reset_n(reset_n), .bus(pif_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        pif.btn_up_raw = 1'b1; pif.btn_down_raw = 1'b1;
        pif.step_en = 1'b1; pif.freeze = 1'b0; pif.center = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (pif.paddle_loc !== 10'd208) begin errors++; $display("FAIL reset_loc got %0d exp 208", pif.paddle_loc); end
        checks++; if (pif.up_db !== 1'b0 || pif.down_db !== 1'b0) begin errors++; $display("FAIL reset_db got up=%b down=%b exp 0 0", pif.up_db, pif.down_db); end
        checks++; if (pif.moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %b exp 0", pif.moving); end
        checks++; if (pif_t.paddle_loc !== 10'd6) begin errors++; $display("FAIL reset_loc_top got %0d exp 6", pif_t.paddle_loc); end
        checks++; if (pif_b.paddle_loc !== 10'd414) begin errors++; $display("FAIL reset_loc_bot got %0d exp 414", pif_b.paddle_loc); end
        // Up still held after release: no motion until debounce completes.
        pif.btn_down_raw = 1'b0;
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (pif.paddle_loc !== 10'd208 || pif.up_db !== 1'b0) begin errors++; $display("FAIL release_hold k=%0d got loc=%0d up_db=%b exp 208 0", k, pif.paddle_loc, pif.up_db); end
        end
        pif.btn_up_raw = 1'b0;
        reset_pulse();
    endtask

    task automatic test_bounce();
        pif.step_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pif.btn_up_raw = (i % 2 == 0);
            tick();
            checks++; if (pif.up_db !== 1'b0 || pif.paddle_loc !== 10'd208) begin errors++; $display("FAIL bounce_toggle i=%0d got up_db=%b loc=%0d exp 0 208", i, pif.up_db, pif.paddle_loc); end
        end
        pif.btn_up_raw = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        checks++; if (pif.up_db !== 1'b0) begin errors++; $display("FAIL bounce_early got up_db=%b exp 0", pif.up_db); end
        tick();
        checks++; if (pif.up_db !== 1'b1 || pif.paddle_loc !== 10'd208) begin errors++; $display("FAIL bounce_rise got up_db=%b loc=%0d exp 1 208", pif.up_db, pif.paddle_loc); end
        tick();
        checks++; if (pif.paddle_loc !== 10'd204) begin errors++; $display("FAIL bounce_step1 got %0d exp 204", pif.paddle_loc); end
        tick();
        checks++; if (pif.paddle_loc !== 10'd200) begin errors++; $display("FAIL bounce_step2 got %0d exp 200", pif.paddle_loc); end
        // 3-cycle glitch on down must not reach down_db.
        pif.btn_down_raw = 1'b1;
        repeat (3) tick();
        pif.btn_down_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (pif.down_db !== 1'b0) begin errors++; $display("FAIL glitch k=%0d got down_db=%b exp 0", k, pif.down_db); end
        end
        checks++; if (pif.paddle_loc !== 10'd156) begin errors++; $display("FAIL glitch_loc got %0d exp 156", pif.paddle_loc); end
        pif.btn_up_raw = 1'b0;
        reset_pulse();
    endtask

    task automatic test_clamp();
        pif_t.btn_up_raw = 1'b1;
        pif_b.btn_down_raw = 1'b1;
        repeat (8) tick();
        checks++; if (pif_t.paddle_loc !== 10'd6 || pif_t.at_top !== 1'b0) begin errors++; $display("FAIL clamp_top_idle got loc=%0d at_top=%b exp 6 0", pif_t.paddle_loc, pif_t.at_top); end
        pif_t.step_en = 1'b1;
        pif_b.step_en = 1'b1;
        tick();
        checks++; if (pif_t.paddle_loc !== 10'd2 || pif_t.moving !== 1'b1) begin errors++; $display("FAIL clamp_top1 got loc=%0d mv=%b exp 2 1", pif_t.paddle_loc, pif_t.moving); end
        checks++; if (pif_b.paddle_loc !== 10'd416 || pif_b.moving !== 1'b1 || pif_b.at_bottom !== 1'b1) begin errors++; $display("FAIL clamp_bot1 got loc=%0d mv=%b ab=%b exp 416 1 1", pif_b.paddle_loc, pif_b.moving, pif_b.at_bottom); end
        tick();
        checks++; if (pif_t.paddle_loc !== 10'd0 || pif_t.moving !== 1'b1 || pif_t.at_top !== 1'b1) begin errors++; $display("FAIL clamp_top2 got loc=%0d mv=%b at=%b exp 0 1 1", pif_t.paddle_loc, pif_t.moving, pif_t.at_top); end
        checks++; if (pif_b.paddle_loc !== 10'd416 || pif_b.moving !== 1'b0) begin errors++; $display("FAIL clamp_bot2 got loc=%0d mv=%b exp 416 0", pif_b.paddle_loc, pif_b.moving); end
        tick();
        checks++; if (pif_t.paddle_loc !== 10'd0 || pif_t.moving !== 1'b0 || pif_t.at_top !== 1'b1) begin errors++; $display("FAIL clamp_top3 got loc=%0d mv=%b at=%b exp 0 0 1", pif_t.paddle_loc, pif_t.moving, pif_t.at_top); end
        pif_t.step_en = 1'b0;
        pif_b.step_en = 1'b0;
    endtask

    task automatic test_hold();
        pif.btn_up_raw = 1'b1; pif.btn_down_raw = 1'b1; pif.step_en = 1'b1;
        repeat (8) tick();
        checks++; if (pif.up_db !== 1'b1 || pif.down_db !== 1'b1) begin errors++; $display("FAIL both_db got up=%b down=%b exp 1 1", pif.up_db, pif.down_db); end
        checks++; if (pif.paddle_loc !== 10'd208 || pif.moving !== 1'b0) begin errors++; $display("FAIL both_loc got loc=%0d mv=%b exp 208 0", pif.paddle_loc, pif.moving); end
        pif.btn_up_raw = 1'b0; pif.freeze = 1'b1;
        repeat (8) tick();
        checks++; if (pif.up_db !== 1'b0 || pif.down_db !== 1'b1) begin errors++; $display("FAIL freeze_db got up=%b down=%b exp 0 1", pif.up_db, pif.down_db); end
        checks++; if (pif.paddle_loc !== 10'd208) begin errors++; $display("FAIL freeze_loc got %0d exp 208", pif.paddle_loc); end
        pif.freeze = 1'b0; pif.step_en = 1'b0;
        repeat (3) tick();
        checks++; if (pif.paddle_loc !== 10'd208) begin errors++; $display("FAIL nostep_loc got %0d exp 208", pif.paddle_loc); end
        pif.step_en = 1'b1;
        tick();
        checks++; if (pif.paddle_loc !== 10'd212 || pif.moving !== 1'b1) begin errors++; $display("FAIL step_resume got loc=%0d mv=%b exp 212 1", pif.paddle_loc, pif.moving); end
    endtask

    task automatic test_priority();
        repeat (22) tick();
        checks++; if (pif.paddle_loc !== 10'd300) begin errors++; $display("FAIL prio_start got %0d exp 300", pif.paddle_loc); end
        pif.center = 1'b1; pif.freeze = 1'b1;
        tick();
        pif.center = 1'b0; pif.freeze = 1'b0;
        checks++; if (pif.paddle_loc !== 10'd208 || pif.down_db !== 1'b1) begin errors++; $display("FAIL prio_center got loc=%0d down_db=%b exp 208 1", pif.paddle_loc, pif.down_db); end
        tick();
        checks++; if (pif.paddle_loc !== 10'd212) begin errors++; $display("FAIL prio_after got %0d exp 212", pif.paddle_loc); end
    endtask

    task automatic test_rate();
        logic [9:0] exp_loc;
        logic       strobe;
        exp_loc = 10'd212;
        for (int i = 0; i < 12; i++) begin
            strobe = (i % 4 == 0);
            pif.step_en = strobe;
            tick();
            if (strobe) exp_loc = exp_loc + 10'd4;
            checks++; if (pif.paddle_loc !== exp_loc || pif.moving !== strobe) begin errors++; $display("FAIL rate i=%0d got loc=%0d mv=%b exp %0d %b", i, pif.paddle_loc, pif.moving, exp_loc, strobe); end
        end
        checks++; if (pif.paddle_loc !== 10'd224) begin errors++; $display("FAIL rate_end got %0d exp 224", pif.paddle_loc); end
    endtask

    initial begin
        pif_t.btn_up_raw = 1'b0; pif_t.btn_down_raw = 1'b0; pif_t.step_en = 1'b0;
        pif_t.freeze = 1'b0; pif_t.center = 1'b0;
        pif_b.btn_up_raw = 1'b0; pif_b.btn_down_raw = 1'b0; pif_b.step_en = 1'b0;
        pif_b.freeze = 1'b0; pif_b.center = 1'b0;
        test_reset();
        test_bounce();
        test_clamp();
        test_hold();
        test_priority();
        test_rate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
